// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Purpose  : Branch resolve/redirect, queued BTB update writes, BTB sweep FSM
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
   parameter int FIFO_DEPTH  = 4,
   parameter int BTB_ENTRIES = 64,
   parameter int IDX_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             flush_if_id,
   output logic             btb_update,
   output logic [31:0]      btb_update_pc,
   output logic [31:0]      btb_update_target,
   output logic             btb_mispredicted,
   input  logic             btb_ready,
   input  logic             inv_req,
   output logic             btb_inv,
   output logic [IDX_W-1:0] btb_inv_idx,
   output logic             inv_busy,
   output logic             inv_done,
   output logic [31:0]      mispredict_count,
   output logic [15:0]      drop_count
);

   localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
   localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(BTB_ENTRIES - 1);
   localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SWEEP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [64:0]        r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               r_redirect;
   logic [31:0]        r_redirect_pc;
   logic [31:0]        r_mis_cnt;
   logic [15:0]        r_drop_cnt;

   logic        w_resolve;
   logic        w_mispredict;
   logic [31:0] w_seq_pc;
   logic [31:0] w_new_target;
   logic        w_enq;
   logic        w_empty;
   logic        w_full;
   logic        w_deq;
   logic        w_enq_ok;
   logic        w_drop;
   logic [64:0] w_head;

   assign w_resolve    = ex_valid & ex_is_branch;
   assign w_mispredict = w_resolve & ((ex_taken != ex_pred_taken) |
                         (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
   assign w_seq_pc     = ex_pc + 32'd4;
   assign w_new_target = ex_taken ? ex_target : w_seq_pc;
   // Correctly predicted not-taken branches carry nothing worth writing back
   assign w_enq        = w_resolve & (ex_taken | w_mispredict);

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == c_full_cnt);
   assign w_deq    = ((r_state == ST_IDLE) || (r_state == ST_DRAIN)) & ~w_empty & btb_ready;
   assign w_enq_ok = w_enq & (~w_full | w_deq);
   assign w_drop   = w_enq & w_full & ~w_deq;
   assign w_head   = r_mem[r_rd_ptr];

   assign btb_update        = w_deq;
   assign btb_update_pc     = w_deq ? w_head[64:33] : 32'd0;
   assign btb_update_target = w_deq ? w_head[32:1]  : 32'd0;
   assign btb_mispredicted  = w_deq & w_head[0];

   assign redirect         = r_redirect;
   assign flush_if_id      = r_redirect;
   assign redirect_pc      = r_redirect_pc;
   assign mispredict_count = r_mis_cnt;
   assign drop_count       = r_drop_cnt;
   assign btb_inv          = (r_state == ST_SWEEP);
   assign btb_inv_idx      = r_idx;
   assign inv_busy         = (r_state != ST_IDLE);
   assign inv_done         = (r_state == ST_DONE);

   always_ff @(posedge clk) begin
      if (w_enq_ok) begin
         r_mem[r_wr_ptr] <= {ex_pc, w_new_target, w_mispredict};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= 32'd0;
         r_mis_cnt     <= 32'd0;
         r_drop_cnt    <= 16'd0;
      end else begin
         r_redirect <= w_mispredict;
         if (w_mispredict) begin
            r_redirect_pc <= w_new_target;
            if (r_mis_cnt != 32'hFFFF_FFFF) r_mis_cnt <= r_mis_cnt + 32'd1;
         end
         if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

         if (w_enq_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_deq)    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_enq_ok, w_deq})
            2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
            2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
            default: r_count <= r_count;
         endcase

         case (r_state)
            ST_IDLE: begin
               if (inv_req) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_empty) begin
                  r_state <= ST_SWEEP;
                  r_idx   <= '0;
               end
            end
            ST_SWEEP: begin
               // Index parks at zero so it reads 0 whenever no sweep is running
               if (r_idx == c_last_idx) begin
                  r_state <= ST_DONE;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
